// File: rtl/rx_fsrc_pkg.sv
// Shared types and helpers for the receive-side fractional sample-rate converter.
// Holds the control state encoding and the slot extraction helper.
package rx_fsrc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BYPASS,
        WAIT_START,
        RUN
    } state_t;

    // Upper bounds for the generic slot helper; callers cast to their real widths.
    localparam int MAX_DATA_W = 4096;
    localparam int MAX_SLOT_W = 1024;

    function automatic logic [MAX_SLOT_W-1:0] slot_sel(input logic [MAX_DATA_W-1:0] data,
                                                       input int s,
                                                       input int slot_w);
        logic [MAX_DATA_W-1:0] shifted;
        shifted = data >> (s * slot_w);
        return shifted[MAX_SLOT_W-1:0];
    endfunction

endpackage

// File: rtl/rx_fsrc_drop_gen.sv
// Phase accumulator chain: flags the time-slots where the transmitter inserted holes.
// A slot is a hole when its phase increment carries out of the accumulator.
module rx_fsrc_drop_gen #(
    parameter int SPC         = 4,
    parameter int ACCUM_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set,
    input  logic [ACCUM_WIDTH-1:0] set_val,
    input  logic [ACCUM_WIDTH-1:0] add_val,
    input  logic                   advance,
    output logic [SPC-1:0]         drop,
    output logic [ACCUM_WIDTH-1:0] accum
);

    logic [ACCUM_WIDTH-1:0] chain [0:SPC];

    always_comb begin
        drop     = '0;
        chain[0] = accum;
        for (int s = 0; s < SPC; s++) begin
            {drop[s], chain[s+1]} = {1'b0, chain[s]} + {1'b0, add_val};
        end
    end

    // A preload wins over the advance so the loaded phase applies to the next beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            accum <= '0;
        end else if (set) begin
            accum <= set_val;
        end else if (advance) begin
            accum <= chain[SPC];
        end
    end

endmodule

// File: rtl/rx_fsrc.sv
// Receive FSRC top: discards hole slots flagged by the phase accumulator and
// repacks the surviving slots into dense output beats.
module rx_fsrc import rx_fsrc_pkg::*; #(
    parameter int NUM_OF_CHANNELS     = 4,
    parameter int SAMPLES_PER_CHANNEL = 4,
    parameter int SAMPLE_DATA_WIDTH   = 16,
    parameter int ACCUM_WIDTH         = 64,
    localparam int SPC        = SAMPLES_PER_CHANNEL,
    localparam int SLOT_W     = NUM_OF_CHANNELS * SAMPLE_DATA_WIDTH,
    localparam int DATA_WIDTH = SLOT_W * SPC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   accum_set,
    input  logic [ACCUM_WIDTH-1:0] accum_set_val,
    input  logic [ACCUM_WIDTH-1:0] accum_add_val,
    input  logic                   s_axis_valid,
    output logic                   s_axis_ready,
    input  logic [DATA_WIDTH-1:0]  s_axis_data,
    output logic                   m_axis_valid,
    input  logic                   m_axis_ready,
    output logic [DATA_WIDTH-1:0]  m_axis_data,
    output logic [31:0]            drop_count
);

    localparam int FILL_W = $clog2(2 * SPC);
    localparam int BUF_N  = (SPC > 1) ? SPC - 1 : 1;

    state_t                 state, state_next;
    logic                   out_valid;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [FILL_W-1:0]      fill;
    logic [SLOT_W-1:0]      slot_buf [BUF_N];
    logic [SLOT_W-1:0]      cat [2*SPC];
    logic [FILL_W-1:0]      total;
    logic                   full;
    logic [DATA_WIDTH-1:0]  out_pack;
    logic [SPC-1:0]         drop;
    logic [ACCUM_WIDTH-1:0] phase;
    logic [32:0]            drop_sum;
    logic                   s_fire, m_fire, run_fire, byp_fire;

    assign s_axis_ready = (state != IDLE) && (!out_valid || m_axis_ready);
    assign m_axis_valid = out_valid;
    assign m_axis_data  = out_data;
    assign s_fire       = s_axis_valid && s_axis_ready;
    assign m_fire       = out_valid && m_axis_ready;
    assign byp_fire     = s_fire && (state == BYPASS);
    assign run_fire     = s_fire && (state == RUN) && enable && !stop;

    rx_fsrc_drop_gen #(
        .SPC         (SPC),
        .ACCUM_WIDTH (ACCUM_WIDTH)
    ) u_drop_gen (
        .clk     (clk),
        .reset   (reset),
        .set     (accum_set),
        .set_val (accum_set_val),
        .add_val (accum_add_val),
        .advance (run_fire),
        .drop    (drop),
        .accum   (phase)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:       state_next = enable ? WAIT_START : BYPASS;
            BYPASS:     if (enable && !out_valid) state_next = WAIT_START;
            WAIT_START: if (!enable) state_next = IDLE;
                        else if (start && !stop) state_next = RUN;
            RUN:        if (!enable) state_next = IDLE;
                        else if (stop) state_next = WAIT_START;
            default:    state_next = IDLE;
        endcase
    end

    // Buffered slots first, then this beat's kept slots in ascending order.
    always_comb begin
        for (int i = 0; i < 2 * SPC; i++) cat[i] = '0;
        for (int i = 0; i < SPC - 1; i++) cat[i] = slot_buf[i];
        total = fill;
        for (int s = 0; s < SPC; s++) begin
            if (!drop[s]) begin
                cat[total] = SLOT_W'(slot_sel(MAX_DATA_W'(s_axis_data), s, SLOT_W));
                total      = total + FILL_W'(1);
            end
        end
        full     = int'(total) >= SPC;
        out_pack = '0;
        for (int i = 0; i < SPC; i++) out_pack[i*SLOT_W +: SLOT_W] = cat[i];
        drop_sum = {1'b0, drop_count} + 33'($countones(drop));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            fill       <= '0;
            drop_count <= '0;
        end else begin
            state <= state_next;
            if (m_fire) out_valid <= 1'b0;
            if (byp_fire) begin
                out_valid <= 1'b1;
                out_data  <= s_axis_data;
            end
            if (run_fire) begin
                if (full) begin
                    out_valid <= 1'b1;
                    out_data  <= out_pack;
                    fill      <= total - FILL_W'(SPC);
                end else begin
                    fill <= total;
                end
                drop_count <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
            end
            if (state == RUN && (stop || !enable)) fill <= '0;
            if (state == RUN && !enable) out_valid <= 1'b0;
        end
    end

    // NOTE: slot storage is not reset; fill alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (run_fire) begin
            for (int i = 0; i < SPC - 1; i++) slot_buf[i] <= full ? cat[i+SPC] : cat[i];
        end
    end

    fill_bound: assert property (@(posedge clk) disable iff (reset) int'(fill) <= SPC - 1);
    accum_load: assert property (@(posedge clk) disable iff (reset)
                                 accum_set |=> phase == $past(accum_set_val));

endmodule

// File: tb/tb_rx_fsrc.sv
// Directed bench for rx_fsrc: pass-through, hole dropping/repacking, backpressure,
// stop/restart and bypass/reset behaviour with hand-computed expected beats.
module tb_rx_fsrc;

    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          accum_set = 1'b0;
    logic [63:0]   accum_set_val = '0;
    logic [63:0]   accum_add_val = '0;
    logic          s_axis_valid = 1'b0;
    logic          s_axis_ready;
    logic [DW-1:0] s_axis_data = '0;
    logic          m_axis_valid;
    logic          m_axis_ready = 1'b1;
    logic [DW-1:0] m_axis_data;
    logic [31:0]   drop_count;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [DW-1:0] rx_q [$];
    logic [DW-1:0] held;

    rx_fsrc dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .start         (start),
        .stop          (stop),
        .accum_set     (accum_set),
        .accum_set_val (accum_set_val),
        .accum_add_val (accum_add_val),
        .s_axis_valid  (s_axis_valid),
        .s_axis_ready  (s_axis_ready),
        .s_axis_data   (s_axis_data),
        .m_axis_valid  (m_axis_valid),
        .m_axis_ready  (m_axis_ready),
        .m_axis_data   (m_axis_data),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_axis_valid && m_axis_ready) rx_q.push_back(m_axis_data);
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_slot(input int b, input int s);
        logic [63:0] v;
        logic [7:0]  bb;
        logic [3:0]  ss, cc;
        bb = 8'(b);
        ss = 4'(s);
        for (int c = 0; c < 4; c++) begin
            cc = 4'(c);
            v[c*16 +: 16] = {bb, ss, cc};
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] mk_beat(input int b);
        logic [DW-1:0] v;
        for (int s = 0; s < 4; s++) v[s*64 +: 64] = mk_slot(b, s);
        return v;
    endfunction

    // Slot 3 dropped every beat: four beats starting at b give three dense beats.
    function automatic logic [DW-1:0] q62_out(input int b, input int k);
        case (k)
            0:       return {mk_slot(b+1, 0), mk_slot(b, 2), mk_slot(b, 1), mk_slot(b, 0)};
            1:       return {mk_slot(b+2, 1), mk_slot(b+2, 0), mk_slot(b+1, 2), mk_slot(b+1, 1)};
            default: return {mk_slot(b+3, 2), mk_slot(b+3, 1), mk_slot(b+3, 0), mk_slot(b+2, 2)};
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input int b);
        bit ok;
        ok = 1'b0;
        s_axis_valid = 1'b1;
        s_axis_data  = mk_beat(b);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = s_axis_ready;
            @(posedge clk);
            #1;
        end
        s_axis_valid = 1'b0;
        chk1($sformatf("accept_beat_%0d", b), ok, 1'b1);
    endtask

    task automatic arm(input logic [63:0] add);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        accum_set     = 1'b1;
        accum_set_val = '0;
        accum_add_val = add;
        step(1);
        accum_set = 1'b0;
        start     = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        step(2);
        chk1("rst_m_valid", m_axis_valid, 1'b0);
        chkv("rst_m_data", m_axis_data, '0);
        chk1("rst_s_ready", s_axis_ready, 1'b0);
        chkv("rst_drop_count", DW'(drop_count), '0);
        reset = 1'b0;
        step(1);

        // add_val = 0: identical beats, one cycle latency, no drops
        arm(64'h0);
        rx_q.delete();
        send_beat(1);
        chk1("pass_latency_valid", m_axis_valid, 1'b1);
        chkv("pass_latency_data", m_axis_data, mk_beat(1));
        for (int b = 2; b <= 4; b++) send_beat(b);
        step(2);
        chkv("pass_count", DW'(rx_q.size()), DW'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < rx_q.size()) chkv($sformatf("pass_beat_%0d", i), rx_q[i], mk_beat(i + 1));
        end
        chkv("pass_drops", DW'(drop_count), '0);

        // add_val = 2^63: slots 1 and 3 dropped
        arm(64'h8000_0000_0000_0000);
        rx_q.delete();
        send_beat(5);
        chk1("half_no_output_yet", m_axis_valid, 1'b0);
        chkv("half_drops_one_beat", DW'(drop_count), DW'(2));
        send_beat(6);
        chkv("half_data", m_axis_data,
             {mk_slot(6, 2), mk_slot(6, 0), mk_slot(5, 2), mk_slot(5, 0)});
        step(2);
        chkv("half_count", DW'(rx_q.size()), DW'(1));
        chkv("half_drops", DW'(drop_count), DW'(4));

        // add_val = 2^62: slot 3 dropped, 4 beats in -> 3 beats out
        arm(64'h4000_0000_0000_0000);
        rx_q.delete();
        for (int b = 7; b <= 10; b++) send_beat(b);
        step(2);
        chkv("q62_count", DW'(rx_q.size()), DW'(3));
        for (int k = 0; k < 3; k++) begin
            if (k < rx_q.size()) chkv($sformatf("q62_beat_%0d", k), rx_q[k], q62_out(7, k));
        end
        chkv("q62_drops", DW'(drop_count), DW'(8));

        // Same pattern under 5 cycles of output backpressure
        arm(64'h4000_0000_0000_0000);
        rx_q.delete();
        m_axis_ready = 1'b0;
        send_beat(11);
        send_beat(12);
        held = q62_out(11, 0);
        s_axis_valid = 1'b1;
        s_axis_data  = mk_beat(13);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk1($sformatf("bp_valid_%0d", i), m_axis_valid, 1'b1);
            chkv($sformatf("bp_data_%0d", i), m_axis_data, held);
            chk1($sformatf("bp_s_ready_%0d", i), s_axis_ready, 1'b0);
        end
        m_axis_ready = 1'b1;
        send_beat(13);
        send_beat(14);
        step(2);
        chkv("bp_count", DW'(rx_q.size()), DW'(3));
        for (int k = 0; k < 3; k++) begin
            if (k < rx_q.size()) chkv($sformatf("bp_beat_%0d", k), rx_q[k], q62_out(11, k));
        end
        chkv("bp_drops", DW'(drop_count), DW'(12));

        // Stop with two slots buffered, then restart: buffered slots are gone
        arm(64'h8000_0000_0000_0000);
        rx_q.delete();
        send_beat(15);
        chkv("stop_fill_before", DW'(dut.fill), DW'(2));
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        send_beat(16);
        chk1("restart_no_output_yet", m_axis_valid, 1'b0);
        send_beat(17);
        step(2);
        chkv("restart_count", DW'(rx_q.size()), DW'(1));
        if (rx_q.size() > 0)
            chkv("restart_beat", rx_q[0],
                 {mk_slot(17, 2), mk_slot(17, 0), mk_slot(16, 2), mk_slot(16, 0)});
        chkv("restart_drops", DW'(drop_count), DW'(18));

        // Bypass: no drops even with a dropping increment, then reset with a held beat
        enable = 1'b0;
        step(3);
        rx_q.delete();
        send_beat(18);
        chk1("byp_valid", m_axis_valid, 1'b1);
        chkv("byp_data", m_axis_data, mk_beat(18));
        step(1);
        m_axis_ready = 1'b0;
        send_beat(19);
        chk1("byp_held_valid", m_axis_valid, 1'b1);
        chkv("byp_drops", DW'(drop_count), DW'(18));
        reset = 1'b1;
        step(1);
        chk1("mid_rst_m_valid", m_axis_valid, 1'b0);
        chk1("mid_rst_s_ready", s_axis_ready, 1'b0);
        chkv("mid_rst_fill", DW'(dut.fill), '0);
        chkv("mid_rst_drops", DW'(drop_count), '0);
        reset = 1'b0;
        m_axis_ready = 1'b1;
        step(4);
        chk1("post_rst_m_valid", m_axis_valid, 1'b0);
        chkv("post_rst_count", DW'(rx_q.size()), DW'(1));
        if (rx_q.size() > 0) chkv("post_rst_beat", rx_q[0], mk_beat(18));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
